// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding, the
// default timing for a 50 MHz reference clock, output widths and the
// constant-function helpers used to size the shared cycle counter.
package pll_lock_supervisor_pkg;

   // Debug-visible state encoding; these values appear on state_o.
   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   // Default timing for a 50 MHz reference (20 ns per cycle):
   // 2 us PLL reset pulse, 1 ms lock timeout, ~20 us of stable lock.
   localparam int unsigned DEF_RST_CYCLES    = 100;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_MAX_RETRY     = 3;
   localparam int unsigned DEF_SYNC_STAGES   = 2;

   // Widths of the status outputs.
   localparam int STATE_W = 3;
   localparam int RETRY_W = 4;
   localparam int LOSS_W  = 8;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int unsigned clog2_fn(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Largest of three cycle counts, used to size the shared counter.
   function automatic int unsigned max3_fn(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Control and status bundle of the PLL lock supervisor. The master side
// (board logic or a bench) drives the raw lock and restart request; the
// slave side is the supervisor itself.
interface pll_lock_supervisor_if;
   import pll_lock_supervisor_pkg::*;

   logic               pll_lock;
   logic               restart;
   logic               pll_rst;
   logic               sys_rst;
   logic               locked_ok;
   logic               fault;
   logic [RETRY_W-1:0] retry_cnt;
   logic [LOSS_W-1:0]  lock_loss_cnt;
   logic [STATE_W-1:0] state_o;

   modport master (
      output pll_lock,
      output restart,
      input  pll_rst,
      input  sys_rst,
      input  locked_ok,
      input  fault,
      input  retry_cnt,
      input  lock_loss_cnt,
      input  state_o
   );

   modport slave (
      input  pll_lock,
      input  restart,
      output pll_rst,
      output sys_rst,
      output locked_ok,
      output fault,
      output retry_cnt,
      output lock_loss_cnt,
      output state_o
   );

endinterface

// File: rtl/pll_lock_supervisor_sync_bit.sv
// sync_bit: a STAGES-deep flop chain that brings a single asynchronous
// level into the clk domain. The asynchronous clear forces the chain to 0,
// so a freshly reset consumer never sees a stale 1. Also used by the
// per-domain reset synchronisers downstream of the supervisor.
module sync_bit
   import pll_lock_supervisor_pkg::*;
#(
   parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw input through the chain, oldest sample at the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor. Holds the PLL in reset, waits (with a timeout) for
// the synchronised lock, debounces it, and only then releases the
// downstream system reset. A failed attempt (timeout or lock loss while
// running) re-runs the sequence until the retry budget is spent, after
// which the block parks in FAULT until restart or rst.
// Must be clocked by the PLL reference, never by a PLL output.
module pll_lock_supervisor
   import pll_lock_supervisor_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input logic                  sys_clk,
   input logic                  rst,
   pll_lock_supervisor_if.slave bus
);

   // One counter serves every timed state, so it is sized for the longest.
   localparam int unsigned MAX_CNT   = max3_fn(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int unsigned CNT_W_RAW = clog2_fn(MAX_CNT);
   localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

   // Terminal counts: each timed state lasts exactly its cycle count.
   localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);

   // A one-flop synchroniser is not safe against metastability.
   localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [RETRY_W-1:0] RETRY_SAT = '1;
   localparam logic [LOSS_W-1:0]  LOSS_SAT  = '1;

   logic               lock_s;

   state_t             state_q, state_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [RETRY_W-1:0] retry_q, retry_n;
   logic [LOSS_W-1:0]  loss_q, loss_n;
   logic               attempt_failed;

   logic               pll_rst_q, pll_rst_n;
   logic               sys_rst_q, sys_rst_n;
   logic               locked_ok_q, locked_ok_n;
   logic               fault_q, fault_n;

   sync_bit #(
      .STAGES (SYNC_N)
   ) u_lock_sync (
      .clk (sys_clk),
      .rst (rst),
      .d   (bus.pll_lock),
      .q   (lock_s)
   );

   // State, counters and the reset outputs, all cleared straight into the safe state.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RESET;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         locked_ok_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         retry_q     <= retry_n;
         loss_q      <= loss_n;
         pll_rst_q   <= pll_rst_n;
         sys_rst_q   <= sys_rst_n;
         locked_ok_q <= locked_ok_n;
         fault_q     <= fault_n;
      end
   end

   // Next state and counters; restart is applied last so it overrides everything.
   always_comb begin
      state_n        = state_q;
      cnt_n          = cnt_q;
      retry_n        = retry_q;
      loss_n         = loss_q;
      attempt_failed = 1'b0;

      case (state_q)
         ST_RESET: begin
            if (cnt_q == RST_TC) begin
               state_n = ST_WAIT_LOCK;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end

         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_n = ST_STABLE;
               cnt_n   = '0;
            end else if (cnt_q == LOCK_TC) begin
               attempt_failed = 1'b1;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end

         ST_STABLE: begin
            if (!lock_s) begin
               state_n = ST_WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt_q == STABLE_TC) begin
               state_n = ST_RUN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end

         ST_RUN: begin
            cnt_n = '0;
            if (!lock_s) begin
               attempt_failed = 1'b1;
               if (loss_q != LOSS_SAT) begin
                  loss_n = loss_q + 1'b1;
               end
            end
         end

         ST_FAULT: begin
            cnt_n = '0;
         end

         default: begin
            state_n = ST_RESET;
            cnt_n   = '0;
         end
      endcase

      if (attempt_failed) begin
         cnt_n = '0;
         if (32'(retry_q) < MAX_RETRY) begin
            state_n = ST_RESET;
            if (retry_q != RETRY_SAT) begin
               retry_n = retry_q + 1'b1;
            end
         end else begin
            state_n = ST_FAULT;
         end
      end

      if (bus.restart) begin
         state_n = ST_RESET;
         cnt_n   = '0;
         retry_n = '0;
         loss_n  = loss_q;
      end

      pll_rst_n   = (state_n == ST_RESET) || (state_n == ST_FAULT);
      sys_rst_n   = (state_n != ST_RUN);
      locked_ok_n = (state_n == ST_RUN);
      fault_n     = (state_n == ST_FAULT);
   end

   assign bus.pll_rst       = pll_rst_q;
   assign bus.sys_rst       = sys_rst_q;
   assign bus.locked_ok     = locked_ok_q;
   assign bus.fault         = fault_q;
   assign bus.retry_cnt     = retry_q;
   assign bus.lock_loss_cnt = loss_q;
   assign bus.state_o       = state_q;

endmodule
